// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory, decode and pc write-port bundle for instr_fetch
interface instr_fetch_if #(
    parameter int DATA_W    = 16,
    parameter int RF_ADDR_W = 4
);
    logic                 imem_req;
    logic [DATA_W-1:0]    imem_addr;
    logic                 imem_ack;
    logic [DATA_W-1:0]    imem_rdata;
    logic [DATA_W-1:0]    ir;
    logic                 ir_valid;
    logic                 ir_ready;
    logic [DATA_W-1:0]    pc;
    logic                 wb_busy;
    logic                 pc_wr;
    logic [RF_ADDR_W-1:0] pc_waddr;
    logic [DATA_W-1:0]    pc_wdata;

    modport master (
        output imem_req, imem_addr, ir, ir_valid, pc_wr, pc_waddr, pc_wdata,
        input  imem_ack, imem_rdata, ir_ready, pc, wb_busy
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, pc_wr, pc_waddr, pc_wdata,
        output imem_ack, imem_rdata, ir_ready, pc, wb_busy
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: pc read, imem req/ack, ir to decode, pc+PC_INC writeback
// Optional ack timeout with sticky fetch_err when INSTR_FETCH_TIMEOUT_EN is defined.
module instr_fetch #(
    parameter int DATA_W    = 16,
    parameter int RF_ADDR_W = 4,
    parameter int PC_ADDR   = 15,
    parameter int PC_INC    = 1
`ifdef INSTR_FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    instr_fetch_if.master bus,
    output logic          busy,
    output logic          fetch_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] PC_UPD = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              flush_pend;
    logic              start_fetch;
    logic [DATA_W-1:0] fetch_addr;
    logic              ack;
    logic              drop;
    logic              timed_out;
    logic              fetch_ok;

    assign ack          = bus.imem_ack && bus.imem_req;
    assign drop         = flush || flush_pend;
    assign bus.pc_waddr = RF_ADDR_W'(PC_ADDR);

`ifdef INSTR_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign timed_out = (state == FETCH) && !ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign fetch_ok  = !fetch_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (start_fetch)
                tmo_cnt <= '0;
            else if (state == FETCH && !ack)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (timed_out)
                fetch_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign fetch_ok  = 1'b1;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        fetch_addr  = bus.pc;
        case (state)
            IDLE: begin
                if (en && fetch_ok) begin
                    state_nxt   = FETCH;
                    start_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (timed_out) begin
                    state_nxt = IDLE;
                end else if (ack) begin
                    if (!drop)
                        state_nxt = PC_UPD;
                    else if (en) begin
                        state_nxt   = FETCH;
                        start_fetch = 1'b1;
                    end else
                        state_nxt = IDLE;
                end
            end
            PC_UPD: begin
                if (flush) begin
                    state_nxt   = en ? FETCH : IDLE;
                    start_fetch = en;
                end else if (!bus.wb_busy) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (flush || bus.ir_ready) begin
                    state_nxt   = en ? FETCH : IDLE;
                    start_fetch = en;
                    // The register file commits pc_wdata on this same edge, so forward it.
                    if (bus.pc_wr && !flush)
                        fetch_addr = bus.pc_wdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            flush_pend    <= 1'b0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
            bus.ir        <= '0;
            bus.ir_valid  <= 1'b0;
            bus.pc_wr     <= 1'b0;
            bus.pc_wdata  <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != IDLE);
            bus.ir_valid <= (state_nxt == HOLD);

            if (start_fetch) begin
                bus.imem_req  <= 1'b1;
                bus.imem_addr <= fetch_addr;
            end else if (state == FETCH && (ack || timed_out)) begin
                bus.imem_req <= 1'b0;
            end

            if (state == FETCH && !(ack || timed_out))
                flush_pend <= flush_pend || flush;
            else
                flush_pend <= 1'b0;

            if (state == FETCH && ack && !drop)
                bus.ir <= bus.imem_rdata;

            bus.pc_wr <= (state == PC_UPD) && !flush && !bus.wb_busy;
            if (state == PC_UPD && !flush && !bus.wb_busy)
                bus.pc_wdata <= bus.pc + DATA_W'(PC_INC);
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        fetch_err;
    logic        wb_we = 1'b0;
    logic [15:0] wb_data = '0;
    logic [15:0] rf_pc = '0;
    logic [15:0] rdata_v = '0;
    logic        echo = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    instr_fetch_if #(.DATA_W(16), .RF_ADDR_W(4)) bus ();

`ifdef INSTR_FETCH_TIMEOUT_EN
    instr_fetch #(.DATA_W(16), .RF_ADDR_W(4), .PC_ADDR(15), .PC_INC(1), .TIMEOUT(8)) dut (
`else
    instr_fetch #(.DATA_W(16), .RF_ADDR_W(4), .PC_ADDR(15), .PC_INC(1)) dut (
`endif
        .clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Register-file pc entry: writeback wins the shared port over fetch.
    always @(posedge clk) begin
        if (wb_we)
            rf_pc <= wb_data;
        else if (bus.pc_wr)
            rf_pc <= bus.pc_wdata;
    end

    assign bus.pc         = rf_pc;
    assign bus.imem_rdata = echo ? (bus.imem_addr ^ 16'h1234) : rdata_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] v);
        wb_we = 1'b1;
        wb_data = v;
        tick();
        wb_we = 1'b0;
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.ir_ready = 1'b0;
        bus.wb_busy  = 1'b0;

        // reset state
        tick(); tick();
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_ir", bus.ir, 0);
        check("rst_valid", bus.ir_valid, 0);
        check("rst_pcwr", bus.pc_wr, 0);
        check("rst_wdata", bus.pc_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", fetch_err, 0);
        check("rst_waddr", bus.pc_waddr, 15);
        rst = 1'b1;

        // single fetch, one wait cycle before ack
        set_pc(16'h0010);
        en = 1'b1;
        tick();
        check("t1_req", bus.imem_req, 1);
        check("t1_addr", bus.imem_addr, 16'h0010);
        check("t1_busy", busy, 1);
        en = 1'b0;
        tick();
        check("t1_req_hold", bus.imem_req, 1);
        check("t1_addr_hold", bus.imem_addr, 16'h0010);
        bus.imem_ack = 1'b1;
        rdata_v = 16'hA5C3;
        tick();
        bus.imem_ack = 1'b0;
        check("t1_req_drop", bus.imem_req, 0);
        check("t1_ir", bus.ir, 16'hA5C3);
        check("t1_valid_early", bus.ir_valid, 0);
        check("t1_pcwr_early", bus.pc_wr, 0);
        tick();
        check("t1_pcwr", bus.pc_wr, 1);
        check("t1_wdata", bus.pc_wdata, 16'h0011);
        check("t1_valid", bus.ir_valid, 1);
        tick();
        check("t1_pcwr_once", bus.pc_wr, 0);
        check("t1_valid_wait", bus.ir_valid, 1);
        check("t1_rf_pc", rf_pc, 16'h0011);
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        check("t1_valid_off", bus.ir_valid, 0);
        check("t1_idle", busy, 0);

        // back-to-back zero-wait fetches, one instruction per 3 cycles
        set_pc(16'h0000);
        echo = 1'b1;
        bus.imem_ack = 1'b1;
        bus.ir_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b2b_req", bus.imem_req, 1);
            check("b2b_addr", bus.imem_addr, i);
            tick();
            check("b2b_ir", bus.ir, 16'(i) ^ 16'h1234);
            tick();
            check("b2b_valid", bus.ir_valid, 1);
            check("b2b_pcwr", bus.pc_wr, 1);
            check("b2b_wdata", bus.pc_wdata, i + 1);
        end
        en = 1'b0;
        bus.imem_ack = 1'b0;
        tick();
        bus.ir_ready = 1'b0;
        echo = 1'b0;
        check("b2b_idle", busy, 0);
        check("b2b_valid_off", bus.ir_valid, 0);

        // writeback stall in PC_UPD
        set_pc(16'h0100);
        rdata_v = 16'hBEEF;
        bus.imem_ack = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        bus.wb_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pcwr", bus.pc_wr, 0);
            check("stall_valid", bus.ir_valid, 0);
            check("stall_busy", busy, 1);
        end
        bus.wb_busy = 1'b0;
        tick();
        check("stall_pcwr_go", bus.pc_wr, 1);
        check("stall_wdata", bus.pc_wdata, 16'h0101);
        check("stall_valid_go", bus.ir_valid, 1);
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        check("stall_pcwr_once", bus.pc_wr, 0);
        check("stall_idle", busy, 0);

        // flush during FETCH, ack two cycles later, pc redirected to 0x0200
        set_pc(16'h0300);
        en = 1'b1;
        tick();
        check("fl_addr0", bus.imem_addr, 16'h0300);
        flush = 1'b1;
        wb_we = 1'b1;
        wb_data = 16'h0200;
        tick();
        flush = 1'b0;
        wb_we = 1'b0;
        check("fl_req_hold", bus.imem_req, 1);
        check("fl_addr_hold", bus.imem_addr, 16'h0300);
        tick();
        bus.imem_ack = 1'b1;
        rdata_v = 16'hDEAD;
        tick();
        bus.imem_ack = 1'b0;
        en = 1'b0;
        check("fl_ir_kept", bus.ir, 16'hBEEF);
        check("fl_no_pcwr", bus.pc_wr, 0);
        check("fl_refetch_req", bus.imem_req, 1);
        check("fl_refetch_addr", bus.imem_addr, 16'h0200);
        bus.imem_ack = 1'b1;
        rdata_v = 16'h1111;
        tick();
        bus.imem_ack = 1'b0;
        check("fl_ir_new", bus.ir, 16'h1111);
        tick();
        check("fl_wdata", bus.pc_wdata, 16'h0201);
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        check("fl_idle", busy, 0);

        // pc wrap and flush in HOLD
        set_pc(16'hFFFF);
        rdata_v = 16'h7777;
        bus.imem_ack = 1'b1;
        en = 1'b1;
        tick();
        check("wr_addr", bus.imem_addr, 16'hFFFF);
        en = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("wr_wdata", bus.pc_wdata, 16'h0000);
        check("wr_valid", bus.ir_valid, 1);
        flush = 1'b1;
        bus.ir_ready = 1'b1;
        tick();
        flush = 1'b0;
        bus.ir_ready = 1'b0;
        check("hold_flush_valid", bus.ir_valid, 0);
        check("hold_flush_idle", busy, 0);
        check("wr_rf_pc", rf_pc, 16'h0000);

`ifdef INSTR_FETCH_TIMEOUT_EN
        // ack never arrives: 8 request cycles then sticky error
        set_pc(16'h0040);
        en = 1'b1;
        tick();
        check("to_req", bus.imem_req, 1);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("to_req_wait", bus.imem_req, 1);
        end
        tick();
        check("to_req_drop", bus.imem_req, 0);
        check("to_err", fetch_err, 1);
        check("to_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("to_blocked", bus.imem_req, 0);
            check("to_err_sticky", fetch_err, 1);
        end
        en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
